// File: rtl/seq_sched.sv
// seq_sched: sequencing and arbitration controller for a shared serial pattern detector
// (1101 / 0110, overlapping). Two requesters submit WIDTH-bit words over valid/ready.
// The block round-robin arbitrates, clears the detector for one cycle, shifts the word
// out one bit per cycle, then drains FLAG_LAT zero bits. It counts the detector hits that
// belong to the word's own bits and returns the count and requester ID over a
// valid/ready response channel.
//
// Ports:
//   clk, rst_n             clock (posedge) and synchronous active-low reset
//   req0_valid/data/ready  requester 0 (ready is a combinational one-cycle accept pulse)
//   req1_valid/data/ready  requester 1
//   det_rst_n, det_din     registered detector reset and serial bit (detector samples on negedge)
//   det_flag               detector hit output
//   rsp_valid/id/count     response, held stable until rsp_ready
//   rsp_ready              response consumer ready
//
// Configuration macro: SEQ_SCHED_LSB_FIRST_EN -- when defined, words are shifted LSB first;
// otherwise MSB first. Latency, count window and arbitration are unaffected.
module seq_sched #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned FLAG_LAT = 2,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             det_rst_n,
    output logic             det_din,
    input  logic             det_flag,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [CNT_W-1:0] rsp_count,
    input  logic             rsp_ready
);

    localparam int unsigned NumIdx = WIDTH + FLAG_LAT;
    localparam int unsigned IdxW   = $clog2(NumIdx);

    localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumIdx - 1);
    localparam logic [IdxW-1:0] DrainIdx = IdxW'(WIDTH);
    localparam logic [IdxW-1:0] LatIdx   = IdxW'(FLAG_LAT);

    typedef enum logic [1:0] {StIdle, StClear, StShift, StResp} state_e;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             id_q, id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             det_rst_n_q, det_rst_n_d;
    logic             det_din_q, det_din_d;
    logic             gnt0, gnt1;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        data_d       = data_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        det_din_d    = 1'b0;
        gnt0         = 1'b0;
        gnt1         = 1'b0;

        unique case (state_q)
            StIdle: begin
                // On a tie, requester 0 wins only if requester 1 had the last grant.
                if (rst_n) begin
                    if (req0_valid && (!req1_valid || last_grant_q)) begin
                        gnt0 = 1'b1;
                    end else if (req1_valid) begin
                        gnt1 = 1'b1;
                    end
                end
                if (gnt0 || gnt1) begin
                    data_d       = gnt1 ? req1_data : req0_data;
                    id_d         = gnt1;
                    last_grant_d = gnt1;
                    cnt_d        = '0;
                    state_d      = StClear;
                end
            end
            StClear: begin
                idx_d   = '0;
                state_d = StShift;
            end
            StShift: begin
                // det_flag at index idx belongs to the bit sent at idx - FLAG_LAT.
                if (idx_q >= LatIdx && det_flag && cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (idx_q == LastIdx) begin
                    state_d = StResp;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // det_din is registered, so it is derived from the index the next cycle will hold;
        // the word register doubles as the shift register.
        if (state_d == StShift) begin
`ifdef SEQ_SCHED_LSB_FIRST_EN
            det_din_d = (idx_d < DrainIdx) ? data_q[0] : 1'b0;
            data_d    = data_q >> 1;
`else
            det_din_d = (idx_d < DrainIdx) ? data_q[WIDTH-1] : 1'b0;
            data_d    = data_q << 1;
`endif
        end

        det_rst_n_d = (state_d != StClear);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            data_q       <= '0;
            id_q         <= 1'b0;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            det_rst_n_q  <= 1'b0;
            det_din_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            det_rst_n_q  <= det_rst_n_d;
            det_din_q    <= det_din_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign det_rst_n  = det_rst_n_q;
    assign det_din    = det_din_q;
    assign rsp_valid  = (state_q == StResp);
    assign rsp_id     = id_q;
    assign rsp_count  = cnt_q;

endmodule

// File: doc/seq_sched.md
# seq_sched

Sequencing and arbitration controller for the shared serial pattern detector (1101 / 0110, overlapping, single-bit `flag`). Two requesters each submit a WIDTH-bit word over valid/ready. The block round-robin arbitrates between them, clears the detector, and shifts the word in one bit per cycle. It counts the detector hits attributable to that word and returns the count with the requester ID over a valid/ready response channel.

## Interface
- WIDTH, 8: bits per submitted word.
- FLAG_LAT, 2: cycles from a bit on `det_din` to its hit appearing on `det_flag`, as sampled at posedge.
- CNT_W, 4: width of the hit counter.

- clk  in  1  clock; block logic on posedge. The detector samples `det_din` on the following negedge.
- rst_n  in  1  reset, synchronous, active-low.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  WIDTH  requester 0 word.
- req0_ready  out  1  one-cycle accept pulse for requester 0.
- req1_valid / req1_data / req1_ready: same for requester 1.
- det_rst_n  out  1  registered detector reset, active-low.
- det_din  out  1  registered serial bit to the detector.
- det_flag  in  1  detector hit output.
- rsp_valid  out  1  response available; held until accepted.
- rsp_id  out  1  requester that owns the response.
- rsp_count  out  CNT_W  hits counted for the word.
- rsp_ready  in  1  response consumer ready.

## Operation
- FSM states: IDLE, CLEAR, SHIFT, RESP.
- **IDLE**
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the one not granted last. `last_grant` resets to 1, so requester 0 wins the first tie.
  - The granted `reqN_ready` is driven high combinationally in the same cycle.
  - On that edge: latch data, latch ID, clear the counter, update `last_grant`, go to CLEAR.
- **CLEAR**
  - `det_rst_n` = 0 for exactly one cycle, `det_din` = 0.
  - Go to SHIFT with bit index `idx` = 0.
- **SHIFT**
  - Runs for `idx` = 0 … WIDTH+FLAG_LAT−1.
  - For `idx` < WIDTH, `det_din` = data[WIDTH−1−idx] (MSB first). Otherwise `det_din` = 0 (drain).
  - When `idx` ≥ FLAG_LAT and `det_flag` = 1, increment the counter, saturating at 2^CNT_W−1.
  - Hits caused by drain bits fall after the window and are never counted.
  - After the last index, go to RESP.
- **RESP**
  - `rsp_valid` = 1 with `rsp_id` and `rsp_count` held stable.
  - On `rsp_valid` & `rsp_ready`, go to IDLE. No new grant is issued in that same cycle.
- Patterns never span words, because the detector is cleared before every word.
- A requester whose `valid` drops before it is granted is simply skipped. No state is kept for it.

## Timing
- Reset values: `req0_ready` = `req1_ready` = 0, `det_rst_n` = 0, `det_din` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_count` = 0, state = IDLE.
- `det_rst_n` returns to 1 on the first clock with `rst_n` = 1.
- Acceptance to `rsp_valid`: 1 (CLEAR) + WIDTH + FLAG_LAT + 1 cycles. With the defaults this is 12 cycles.
- Throughput: one word per WIDTH+FLAG_LAT+3 cycles, provided `rsp_ready` is held high.
- `rsp_valid` back-pressure stalls the block indefinitely. No requests are accepted while stalled.
- Reset asserted mid-SHIFT or mid-RESP aborts the operation: the response is discarded, FSM returns to IDLE, `det_rst_n` = 0 on the next edge.
- At most one `reqN_ready` is high in any cycle.

## Configuration
- `SEQ_SCHED_LSB_FIRST_EN`
  - Defined: words are shifted LSB first, `det_din` = data[idx].
  - Undefined (default): MSB first, as described above.
  - Nothing else changes: latency, count window and arbitration are identical.

## Test plan
- **Single word, two pattern types:** req0 sends 8'hDB, `rsp_ready` = 1.
  - Response arrives 12 cycles after accept with `rsp_id` = 0, `rsp_count` = 3 (1101 at bit 3, 0110 at bit 5, 1101 at bit 6).
- **Overlapping 0110, other requester:** req1 sends 8'h66.
  - `rsp_id` = 1, `rsp_count` = 2. req0 sends 8'h00: `rsp_count` = 0.
- **No false hits from drain:** req0 sends 8'hD0.
  - `rsp_count` = 1. The drain zeros add no count.
- **Round-robin tie:** both requesters valid continuously, each sending 8'hDB.
  - Grants alternate 0, 1, 0, 1. Every response has `rsp_count` = 3.
- **Back-pressure:** hold `rsp_ready` = 0 for 20 cycles after `rsp_valid` rises.
  - `rsp_valid`, `rsp_id` and `rsp_count` stay stable. No `reqN_ready` pulses occur. Release leads to IDLE on the next edge.
- **Reset mid-SHIFT:** pulse `rst_n` low at `idx` = 4.
  - All outputs take their reset values on the next edge. No response is produced. The next request completes normally.
